// File: rtl/axil_concat_n_slice_if.sv
// AXI-Lite bundle for NUM_PORTS packed ports. Every field is a flat vector,
// with port i in slice [i*W +: W], so port 0 sits in the LSBs.
//   master : drives aw/w/ar valid+payload and b/r ready (manager side)
//   slave  : drives aw/w/ar ready and b/r valid+payload (subordinate side)
interface axil_concat_n_slice_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
);
  logic [NUM_PORTS-1:0]            awvalid, awready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] awaddr;
  logic [NUM_PORTS-1:0]            wvalid, wready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS*STRB_WIDTH-1:0] wstrb;
  logic [NUM_PORTS-1:0]            bvalid, bready;
  logic [NUM_PORTS*2-1:0]          bresp;
  logic [NUM_PORTS-1:0]            arvalid, arready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] araddr;
  logic [NUM_PORTS-1:0]            rvalid, rready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata;
  logic [NUM_PORTS*2-1:0]          rresp;

  modport master (
    output awvalid, awaddr, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, input arready,
    input  rvalid, rdata, rresp, output rready
  );

  modport slave (
    input  awvalid, awaddr, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/axil_concat_n_slice.sv
// axil_concat_n_slice: packs NUM_PORTS AXI-Lite ports into flat bus vectors.
// It can add a full-throughput 2-entry skid buffer on each channel of each port.
// Ports:
//   aclk     clock
//   aresetn  synchronous active-low reset
//   a        slave modport, facing the endpoint managers (a_* signals)
//   b        master modport, facing the interconnect (b_* signals)
// REG_FWD selects slicing on AW/W/AR (a->b).
// REG_BWD selects slicing on B/R (b->a).
// A value of 0 makes that direction pure wiring.

// Per-channel skid buffer. With REG=0 it is a wire.
// Ready is a register, so the source-side ready never depends combinationally
// on the sink.
module axil_skid #(
  parameter int W   = 32,
  parameter bit REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);
  if (!REG) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign m_valid = s_valid;
    assign s_ready = m_ready;
    assign m_data  = s_data;
  end else begin : g_reg
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t       state, state_nx;
    logic         rdy_q;
    logic [W-1:0] out_q, skid_q;
    logic         push, pop;
    logic         ld_out_src, ld_out_skid, ld_skid;

    assign push = s_valid & rdy_q;
    assign pop  = (state != EMPTY) & m_ready;

    // rdy_q looks ahead at the next state.
    // It reads 0 while in reset and 1 from the first edge after release.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state <= EMPTY;
        rdy_q <= 1'b0;
      end else begin
        state <= state_nx;
        rdy_q <= (state_nx != TWO);
      end
    end

    always_comb begin
      state_nx    = state;
      ld_out_src  = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
      case (state)
        EMPTY: if (push) begin
          state_nx   = ONE;
          ld_out_src = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            ld_out_src = 1'b1;
          end else if (push) begin
            state_nx = TWO;
            ld_skid  = 1'b1;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_nx    = ONE;
          ld_out_skid = 1'b1;
        end
        default: state_nx = EMPTY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q  <= '0;
        skid_q <= '0;
      end else begin
        if (ld_out_src)       out_q <= s_data;
        else if (ld_out_skid) out_q <= skid_q;
        if (ld_skid)          skid_q <= s_data;
      end
    end

    assign s_ready = rdy_q;
    assign m_valid = (state != EMPTY);
    assign m_data  = out_q;
  end
endmodule

module axil_concat_n_slice #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter bit REG_FWD    = 1'b1,
  parameter bit REG_BWD    = 1'b1
) (
  input logic                   aclk,
  input logic                   aresetn,
  axil_concat_n_slice_if.slave  a,
  axil_concat_n_slice_if.master b
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = STRB_WIDTH;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    axil_skid #(.W(AW), .REG(REG_FWD)) u_aw (
      .clk(aclk), .rst_n(aresetn),
      .s_valid(a.awvalid[i]), .s_ready(a.awready[i]), .s_data(a.awaddr[i*AW +: AW]),
      .m_valid(b.awvalid[i]), .m_ready(b.awready[i]), .m_data(b.awaddr[i*AW +: AW])
    );

    axil_skid #(.W(DW+SW), .REG(REG_FWD)) u_w (
      .clk(aclk), .rst_n(aresetn),
      .s_valid(a.wvalid[i]), .s_ready(a.wready[i]),
      .s_data({a.wstrb[i*SW +: SW], a.wdata[i*DW +: DW]}),
      .m_valid(b.wvalid[i]), .m_ready(b.wready[i]),
      .m_data({b.wstrb[i*SW +: SW], b.wdata[i*DW +: DW]})
    );

    axil_skid #(.W(AW), .REG(REG_FWD)) u_ar (
      .clk(aclk), .rst_n(aresetn),
      .s_valid(a.arvalid[i]), .s_ready(a.arready[i]), .s_data(a.araddr[i*AW +: AW]),
      .m_valid(b.arvalid[i]), .m_ready(b.arready[i]), .m_data(b.araddr[i*AW +: AW])
    );

    // The response channels flow from b to a.
    axil_skid #(.W(2), .REG(REG_BWD)) u_b (
      .clk(aclk), .rst_n(aresetn),
      .s_valid(b.bvalid[i]), .s_ready(b.bready[i]), .s_data(b.bresp[i*2 +: 2]),
      .m_valid(a.bvalid[i]), .m_ready(a.bready[i]), .m_data(a.bresp[i*2 +: 2])
    );

    axil_skid #(.W(DW+2), .REG(REG_BWD)) u_r (
      .clk(aclk), .rst_n(aresetn),
      .s_valid(b.rvalid[i]), .s_ready(b.rready[i]),
      .s_data({b.rresp[i*2 +: 2], b.rdata[i*DW +: DW]}),
      .m_valid(a.rvalid[i]), .m_ready(a.rready[i]),
      .m_data({a.rresp[i*2 +: 2], a.rdata[i*DW +: DW]})
    );
  end
endmodule

// File: tb/tb_axil_concat_n_slice.sv
// Directed bench for axil_concat_n_slice.
//   u4 : 4 ports, both directions sliced
//   u2 : 2 ports, pure pass-through
module tb_axil_concat_n_slice;
  logic clk = 1'b0;
  logic aresetn;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axil_concat_n_slice_if #(.NUM_PORTS(4)) a4 ();
  axil_concat_n_slice_if #(.NUM_PORTS(4)) b4 ();
  axil_concat_n_slice_if #(.NUM_PORTS(2)) a2 ();
  axil_concat_n_slice_if #(.NUM_PORTS(2)) b2 ();

  axil_concat_n_slice #(.NUM_PORTS(4), .REG_FWD(1'b1), .REG_BWD(1'b1)) u4 (
    .aclk(clk), .aresetn(aresetn), .a(a4), .b(b4)
  );

  axil_concat_n_slice #(.NUM_PORTS(2), .REG_FWD(1'b0), .REG_BWD(1'b0)) u2 (
    .aclk(clk), .aresetn(aresetn), .a(a2), .b(b2)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pass-through vector: every output must equal a constant in the same cycle.
  task automatic pt_vec(input logic [63:0] p, input logic [63:0] q, input logic [7:0] s);
    a2.awvalid = s[1:0];  a2.awaddr = p;  a2.wvalid = s[3:2]; a2.wdata = q;
    a2.wstrb = s;         a2.arvalid = s[5:4]; a2.araddr = ~p;
    a2.bready = s[7:6];   a2.rready = s[1:0] ^ 2'b11;
    b2.awready = s[3:2] ^ 2'b01; b2.wready = s[5:4] ^ 2'b10; b2.arready = s[7:6];
    b2.bvalid = s[2:1];   b2.bresp = s[7:4]; b2.rvalid = s[6:5];
    b2.rdata = ~q;        b2.rresp = s[3:0];
    #1;
    chk("pt_aw", {b2.awvalid, b2.awaddr}, {s[1:0], p});
    chk("pt_w",  {b2.wvalid, b2.wstrb, b2.wdata}, {s[3:2], s, q});
    chk("pt_ar", {b2.arvalid, b2.araddr}, {s[5:4], ~p});
    chk("pt_rdy_b", {b2.bready, b2.rready}, {s[7:6], s[1:0] ^ 2'b11});
    chk("pt_rdy_a", {a2.awready, a2.wready, a2.arready},
        {s[3:2] ^ 2'b01, s[5:4] ^ 2'b10, s[7:6]});
    chk("pt_b", {a2.bvalid, a2.bresp}, {s[2:1], s[7:4]});
    chk("pt_r", {a2.rvalid, a2.rresp, a2.rdata}, {s[6:5], s[3:0], ~q});
  endtask

  initial begin
    logic [31:0] got[$];
    int          k;
    logic        fire_s;

    aresetn = 1'b0;
    a4.awvalid = '0; a4.awaddr = '0; a4.wvalid = '0; a4.wdata = '0; a4.wstrb = '0;
    a4.arvalid = '0; a4.araddr = '0; a4.bready = '0; a4.rready = '0;
    b4.awready = '0; b4.wready = '0; b4.arready = '0; b4.bvalid = '0; b4.bresp = '0;
    b4.rvalid = '0; b4.rdata = '0; b4.rresp = '0;
    a2.awvalid = '0; a2.awaddr = '0; a2.wvalid = '0; a2.wdata = '0; a2.wstrb = '0;
    a2.arvalid = '0; a2.araddr = '0; a2.bready = '0; a2.rready = '0;
    b2.awready = '0; b2.wready = '0; b2.arready = '0; b2.bvalid = '0; b2.bresp = '0;
    b2.rvalid = '0; b2.rdata = '0; b2.rresp = '0;

    // Reset and idle behaviour.
    tick(); tick();
    chk("rst_valids", {b4.awvalid, b4.wvalid, b4.arvalid, a4.bvalid, a4.rvalid}, 20'h0);
    chk("rst_readies", {a4.awready, a4.wready, a4.arready, b4.bready, b4.rready}, 20'h0);
    chk("rst_data", {b4.awaddr, b4.wdata}, 256'h0);
    aresetn = 1'b1;
    a4.bready = 4'hF; a4.rready = 4'hF;
    tick();
    chk("rel_a_readies", {a4.awready, a4.wready, a4.arready}, 12'hFFF);
    chk("rel_b_readies", {b4.bready, b4.rready}, 8'hFF);

    // Single write on port 2.
    a4.awvalid = 4'h4; a4.awaddr[95:64] = 32'h0000_1040;
    a4.wvalid  = 4'h4; a4.wdata[95:64]  = 32'hDEAD_BEEF; a4.wstrb[11:8] = 4'hF;
    #1;
    chk("wr_not_yet", {b4.awvalid, b4.wvalid}, 8'h00);
    tick();
    a4.awvalid = 4'h0; a4.wvalid = 4'h0;
    chk("wr_valid", {b4.awvalid, b4.wvalid}, 8'h44);
    chk("wr_awaddr", b4.awaddr, 128'h0000_0000_0000_1040_0000_0000_0000_0000);
    chk("wr_wdata", b4.wdata, 128'h0000_0000_DEAD_BEEF_0000_0000_0000_0000);
    chk("wr_wstrb", b4.wstrb, 16'h0F00);
    tick();
    chk("wr_hold", {b4.awvalid, b4.wvalid, b4.awaddr[95:64]}, {8'h44, 32'h0000_1040});
    b4.awready = 4'hF; b4.wready = 4'hF;
    tick();
    chk("wr_drained", {b4.awvalid, b4.wvalid}, 8'h00);
    b4.bvalid = 4'h4; b4.bresp = 8'h00;
    #1;
    chk("b_not_yet", a4.bvalid, 4'h0);
    tick();
    b4.bvalid = 4'h0;
    chk("b_resp", {a4.bvalid, a4.bresp}, {4'h4, 8'h00});
    tick();
    chk("b_drained", a4.bvalid, 4'h0);

    // AR backpressure on port 0: the sink stalls for 3 cycles.
    k = 0;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      a4.arvalid = {3'b000, (k < 8)};
      a4.araddr  = {96'h0, 32'(k * 4)};
      b4.arready = (c >= 3) ? 4'h1 : 4'h0;
      #1;
      if (c == 1) chk("ar_ready_one", a4.arready[0], 1'b1);
      if (c == 2) chk("ar_full", a4.arready[0], 1'b0);
      fire_s = a4.arvalid[0] & a4.arready[0];
      if (b4.arvalid[0] && b4.arready[0]) got.push_back(b4.araddr[31:0]);
      tick();
      if (fire_s) k++;
    end
    a4.arvalid = 4'h0;
    chk("ar_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("ar_addr", got[i], 32'(i * 4));
    tick(); tick();
    chk("ar_no_dup", b4.arvalid, 4'h0);

    // R full throughput on port 1.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        b4.rvalid = 4'h2; b4.rdata = {64'h0, 32'(i), 32'h0}; b4.rresp = 8'b0000_0100;
      end else begin
        b4.rvalid = 4'h0;
      end
      #1;
      if (i == 0) chk("r_first", a4.rvalid, 4'h0);
      else chk("r_beat", {a4.rvalid, a4.rdata[63:32], a4.rresp[3:2]}, {4'h2, 32'(i - 1), 2'b01});
      if (i < 16) chk("r_src_rdy", b4.rready[1], 1'b1);
      tick();
    end
    chk("r_done", a4.rvalid, 4'h0);

    // Mid-transfer reset with the port 3 W slice full.
    b4.wready = 4'h7;
    a4.wvalid = 4'h8; a4.wdata[127:96] = 32'h0000_00A1; a4.wstrb[15:12] = 4'h3;
    tick();
    a4.wdata[127:96] = 32'h0000_00A2;
    tick();
    a4.wvalid = 4'h0;
    chk("w_two", {a4.wready[3], b4.wvalid[3], b4.wdata[127:96]}, {1'b0, 1'b1, 32'h0000_00A1});
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("w_rst", {b4.wvalid[3], a4.wready[3]}, 2'b00);
    tick();
    chk("w_rel", {a4.wready[3], b4.wvalid[3]}, 2'b10);
    b4.wready = 4'hF;
    tick(); tick();
    chk("w_no_stale", b4.wvalid, 4'h0);

    // Pass-through instance, two vectors.
    pt_vec(64'h1111_2222_3333_4444, 64'hCAFE_0001_BEEF_0002, 8'h5A);
    pt_vec(64'hEEEE_DDDD_CCCC_BBBB, 64'h3501_FFFE_4110_FFFD, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
